fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 112 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding memory request, DEPTH-entry FIFO toward decode.
// Optional same-cycle bypass of an empty queue when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
   parameter int              RW       = 16,
   parameter int              I_SIZE   = 32,
   parameter int              DEPTH    = 4,
   parameter logic [RW-1:0]   RESET_PC = '0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   output logic [RW-1:0]     o_req_addr,
   output logic              o_req_active,
   input  logic [I_SIZE-1:0] i_req_data,
   input  logic              i_req_data_valid,
   input  logic              i_next_ready,
   output logic              o_submit,
   output logic [I_SIZE-1:0] o_instr,
   output logic [RW-1:0]     o_pc,
   input  logic              i_flush,
   input  logic [RW-1:0]     i_exec_pc
);

   localparam int            AW   = $clog2(DEPTH);
   localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

   logic [I_SIZE-1:0] mem_instr [DEPTH];
   logic [RW-1:0]     mem_pc    [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count, count_next;
   logic [RW-1:0]     fetch_pc, req_addr, next_pc;
   logic              req_active, discard;
   logic              active_next, discard_next;
   logic              resp, accept, bypass, push, pop, holding;

   always_comb begin
      resp    = req_active & i_req_data_valid;
      accept  = resp & ~discard & ~i_flush;
`ifdef FETCH_QUEUE_BYPASS_EN
      bypass  = accept & (count == '0) & i_next_ready;
`else
      bypass  = 1'b0;
`endif
      push    = accept & ~bypass;
      pop     = (count != '0) & i_next_ready & ~i_flush;
      holding = req_active & ~resp;

      o_submit = pop | bypass;
      o_instr  = bypass ? i_req_data : mem_instr[rd_ptr];
      o_pc     = bypass ? req_addr   : mem_pc[rd_ptr];

      if (i_flush)
         count_next = '0;
      else
         count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

      next_pc = fetch_pc;
      if (i_flush)
         next_pc = i_exec_pc;
      else if (accept)
         next_pc = fetch_pc + 1'b1;

      // A flush over a still-pending request keeps it open and marks its answer for the bin
      active_next  = req_active;
      discard_next = discard;
      if (i_flush) begin
         active_next  = 1'b1;
         discard_next = holding;
      end else if (resp) begin
         active_next  = count_next < FULL;
         discard_next = 1'b0;
      end else if (!req_active) begin
         active_next  = count_next < FULL;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fetch_pc   <= RESET_PC;
         req_addr   <= RESET_PC;
         req_active <= 1'b0;
         discard    <= 1'b0;
      end else begin
         count      <= count_next;
         fetch_pc   <= next_pc;
         req_active <= active_next;
         discard    <= discard_next;
         if (!holding)
            req_addr <= next_pc;
         if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= i_req_data;
         mem_pc[wr_ptr]    <= req_addr;
      end
   end

   assign o_req_addr   = req_addr;
   assign o_req_active = req_active;

endmodule
